spi_master_arbiter: RTL and testbench
=====================================

SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 4, meaning idle cycles between transactions (legal range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the CLK_IN cycles allowed per transaction before abort (legal range 2..65535).
REQ-003 The block SHALL have port CLK_IN  input  1  system clock; all logic on rising edge.
REQ-004 The block SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port EN  input  1  grant enable.
REQ-006 The block SHALL have port REQ  input  4  per-requester transaction request level.
REQ-007 The block SHALL have port TX_DATA  input  64  write words; requester i at bits [16i+15:16i].
REQ-008 The block SHALL have port GNT  output  4  one-hot grant, held for the whole transaction.
REQ-009 The block SHALL have port DONE  output  4  one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have port ERR  output  4  one-cycle timeout pulse to the granted requester.
REQ-011 The block SHALL have port RX_DATA  output  16  last successfully received word.
REQ-012 The block SHALL have port M_START  output  1  start level to the SPI master.
REQ-013 The block SHALL have port M_TXDATA  output  16  latched write word to the SPI master.
REQ-014 The block SHALL have port M_SPI_DONE  input  1  SPI master done flag; a rising edge marks completion.
REQ-015 The block SHALL have port M_RXDATA  input  16  SPI master received word.
REQ-016 The block SHALL have port M_CS_N  input  1  SPI master chip select, active low.
REQ-017 The block SHALL have port CS_N  output  4  per-slave chip selects, active low.

Function
REQ-018 The block SHALL implement states IDLE, WAIT and GAP.
REQ-019 In IDLE with EN=1 and REQ!=0, the block SHALL pick the winner round-robin, starting the search at (last winner+1) mod 4.
REQ-020 On the cycle it picks a winner, the block SHALL latch that winner's TX_DATA slice into M_TXDATA, set GNT to the winner one-hot, set M_START=1, clear the timeout counter and move to WAIT, all registered on the same edge.
REQ-021 In IDLE with EN=0 or REQ=0, the block SHALL stay in IDLE with GNT=0 and M_START=0.
REQ-022 In WAIT, M_START SHALL stay 1 and GNT SHALL stay unchanged.
REQ-023 The block SHALL register M_SPI_DONE once and SHALL detect completion as current=1 while the registered value=0.
REQ-024 On completion in WAIT, the block SHALL on the next edge load M_RXDATA into RX_DATA, pulse DONE[winner] for one cycle, drive GNT=0 and M_START=0, and move to GAP.
REQ-025 In WAIT without completion, the timeout counter SHALL increment each cycle.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse ERR[winner], keep RX_DATA unchanged, drive GNT=0 and M_START=0, and move to GAP.
REQ-027 If completion and timeout occur in the same cycle, completion SHALL win: DONE pulses and ERR does not.
REQ-028 GAP SHALL last exactly GAP_CYCLES cycles with GNT=0 and M_START=0, then return to IDLE; this guarantees a fresh M_START rising edge per transaction.
REQ-029 CS_N[winner] SHALL be driven combinationally from M_CS_N while GNT is nonzero, and every other CS_N bit SHALL be 1; CS_N SHALL be 4'b1111 when GNT=0.
REQ-030 Deasserting REQ or EN during WAIT SHALL NOT abort the transaction.
REQ-031 Changes to TX_DATA after the grant SHALL NOT affect M_TXDATA.
REQ-032 A requester SHALL be able to hold REQ high continuously; it then wins again only after every other pending requester has been served.
REQ-033 Latency from REQ assertion in IDLE to GNT/M_START high SHALL be 1 cycle.
REQ-034 Latency from the M_SPI_DONE rise to the DONE pulse SHALL be 1 cycle.
REQ-035 DONE and ERR SHALL never pulse in the same cycle and SHALL never have more than one bit set.

Reset
REQ-036 While RST_N=0, the block SHALL force state=IDLE, GNT=0, DONE=0, ERR=0, RX_DATA=0, M_START=0, M_TXDATA=0, CS_N=4'b1111, timeout counter=0, GAP counter=0, registered M_SPI_DONE=0 and last winner=3 (so requester 0 has first priority), immediately and regardless of the clock.
REQ-037 A reset during WAIT SHALL abandon the transaction with no DONE or ERR pulse.
REQ-038 The first rising CLK_IN edge after RST_N rises SHALL evaluate the IDLE state normally.

Verification
REQ-039 Bench SHALL cover a single request: REQ=0001, TX_DATA[15:0]=16'hA9A5, M_SPI_DONE rising 40 cycles later with M_RXDATA=16'hF0A5 -> GNT=0001 and M_START=1 one cycle after REQ; M_TXDATA=16'hA9A5; CS_N[0] follows M_CS_N; DONE=0001 for one cycle; RX_DATA=16'hF0A5; GNT=0 for 4 cycles.
REQ-040 Bench SHALL cover fairness: REQ=1111 held from reset -> grants in order 0001, 0010, 0100, 1000, 0001.
REQ-041 Bench SHALL cover timeout with TIMEOUT_CYCLES=16: REQ=0100 and M_SPI_DONE held 0 -> ERR=0100 pulse 16 cycles after grant; RX_DATA unchanged; no DONE pulse.
REQ-042 Bench SHALL cover the simultaneous case: M_SPI_DONE rises on the timeout cycle -> DONE pulses, ERR stays 0.
REQ-043 Bench SHALL cover asynchronous reset: RST_N pulsed low mid-WAIT with REQ=0010 -> GNT=0, M_START=0 and CS_N=1111 immediately; the next grant after reset goes to the lowest pending requester.
REQ-044 Bench SHALL cover EN gating: EN=0 with REQ=0011 -> no grant; EN dropped during WAIT -> transaction still completes with a DONE pulse.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin arbiter granting four requesters access to one SPI master
//
// Purpose:
//   Four requesters share a single SPI master. The arbiter picks one pending
//   requester round-robin and latches its write word. It then holds the grant
//   until the master signals completion or the per-transaction timeout expires.
//   After that it enforces an idle gap, so every transaction starts with a fresh
//   M_START rising edge.
//
// Ports:
//   CLK_IN      in   1   system clock, rising edge
//   RST_N       in   1   asynchronous active-low reset
//   EN          in   1   grant enable (sampled only when choosing a winner)
//   REQ         in   4   per-requester request level
//   TX_DATA     in   64  write words, requester i at [16i+15:16i]
//   GNT         out  4   one-hot grant, held for the whole transaction
//   DONE        out  4   one-cycle completion pulse to the winner
//   ERR         out  4   one-cycle timeout pulse to the winner
//   RX_DATA     out  16  last successfully received word
//   M_START     out  1   start level to the SPI master
//   M_TXDATA    out  16  latched write word to the SPI master
//   M_SPI_DONE  in   1   SPI master done flag, rising edge = completion
//   M_RXDATA    in   16  SPI master received word
//   M_CS_N      in   1   SPI master chip select, active low
//   CS_N        out  4   per-slave chip selects, active low

module spi_master_arbiter #(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        CLK_IN,
  input  logic        RST_N,
  input  logic        EN,
  input  logic [3:0]  REQ,
  input  logic [63:0] TX_DATA,
  output logic [3:0]  GNT,
  output logic [3:0]  DONE,
  output logic [3:0]  ERR,
  output logic [15:0] RX_DATA,
  output logic        M_START,
  output logic [15:0] M_TXDATA,
  input  logic        M_SPI_DONE,
  input  logic [15:0] M_RXDATA,
  input  logic        M_CS_N,
  output logic [3:0]  CS_N
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  done_q, done_d;
  logic [3:0]  err_q, err_d;
  logic [15:0] rx_q, rx_d;
  logic        start_q, start_d;
  logic [15:0] txd_q, txd_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  gap_q, gap_d;
  logic        spi_done_q;
  // Index of the most recent winner; during WAIT it is also the current winner.
  logic [1:0]  last_q, last_d;

  logic        spi_rise;
  logic        found;
  logic [1:0]  pick;
  logic [1:0]  rr_idx;
  logic [3:0]  win_oh;

  assign spi_rise = M_SPI_DONE & ~spi_done_q;
  assign win_oh   = 4'b0001 << last_q;

  // Round-robin search starting just after the last winner; i=4 wraps back
  // to the last winner itself, so a lone requester can win repeatedly.
  always_comb begin
    found  = 1'b0;
    pick   = last_q;
    rr_idx = last_q;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = last_q + 2'(i);
      if (!found && REQ[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 4'b0000;
    err_d   = 4'b0000;
    rx_d    = rx_q;
    start_d = start_q;
    txd_d   = txd_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d   = 4'b0000;
        start_d = 1'b0;
        if (EN && found) begin
          gnt_d   = 4'b0001 << pick;
          start_d = 1'b1;
          txd_d   = TX_DATA[{pick, 4'b0000} +: 16];
          tmo_d   = 16'd0;
          last_d  = pick;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (spi_rise) begin
          rx_d    = M_RXDATA;
          done_d  = win_oh;
          gnt_d   = 4'b0000;
          start_d = 1'b0;
          gap_d   = 8'd0;
          state_d = ST_GAP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = win_oh;
          gnt_d   = 4'b0000;
          start_d = 1'b0;
          gap_d   = 8'd0;
          state_d = ST_GAP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      ST_GAP: begin
        gnt_d   = 4'b0000;
        start_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        gnt_d   = 4'b0000;
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 4'b0000;
      done_q     <= 4'b0000;
      err_q      <= 4'b0000;
      rx_q       <= 16'd0;
      start_q    <= 1'b0;
      txd_q      <= 16'd0;
      tmo_q      <= 16'd0;
      gap_q      <= 8'd0;
      spi_done_q <= 1'b0;
      last_q     <= 2'd3;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rx_q       <= rx_d;
      start_q    <= start_d;
      txd_q      <= txd_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      spi_done_q <= M_SPI_DONE;
      last_q     <= last_d;
    end
  end

  assign GNT      = gnt_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RX_DATA  = rx_q;
  assign M_START  = start_q;
  assign M_TXDATA = txd_q;

  // Granted bit follows the master's chip select; all others stay deselected.
  assign CS_N = ~gnt_q | {4{M_CS_N}};

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - directed self-checking bench for spi_master_arbiter

module tb_spi_master_arbiter;

  logic        CLK_IN = 1'b0;
  logic        RST_N;
  logic        EN;
  logic [3:0]  REQ;
  logic [63:0] TX_DATA;
  logic        M_SPI_DONE;
  logic [15:0] M_RXDATA;
  logic        M_CS_N;

  logic [3:0]  a_gnt, a_done, a_err, a_cs_n;
  logic [15:0] a_rx, a_txd;
  logic        a_start;

  logic [3:0]  b_gnt, b_done, b_err, b_cs_n;
  logic [15:0] b_rx, b_txd;
  logic        b_start;

  int total = 0;
  int bad   = 0;

  always #5 CLK_IN = ~CLK_IN;

  spi_master_arbiter dut_a (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .EN(EN), .REQ(REQ), .TX_DATA(TX_DATA),
    .GNT(a_gnt), .DONE(a_done), .ERR(a_err), .RX_DATA(a_rx),
    .M_START(a_start), .M_TXDATA(a_txd), .M_SPI_DONE(M_SPI_DONE),
    .M_RXDATA(M_RXDATA), .M_CS_N(M_CS_N), .CS_N(a_cs_n)
  );

  spi_master_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_b (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .EN(EN), .REQ(REQ), .TX_DATA(TX_DATA),
    .GNT(b_gnt), .DONE(b_done), .ERR(b_err), .RX_DATA(b_rx),
    .M_START(b_start), .M_TXDATA(b_txd), .M_SPI_DONE(M_SPI_DONE),
    .M_RXDATA(M_RXDATA), .M_CS_N(M_CS_N), .CS_N(b_cs_n)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  task automatic wait_gnt_a();
    int n = 0;
    while (a_gnt == 4'b0000 && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_gnt_b();
    int n = 0;
    while (b_gnt == 4'b0000 && n < 12) begin
      tick();
      n++;
    end
  endtask

  logic [3:0] rr_exp [5];
  logic       early;

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    EN = 1'b0; REQ = 4'b0000; TX_DATA = 64'd0;
    M_SPI_DONE = 1'b0; M_RXDATA = 16'd0; M_CS_N = 1'b0;
    RST_N = 1'b1;

    // Reset state, asserted before any clock edge.
    #2 RST_N = 1'b0;
    #1;
    check("rst_gnt",   a_gnt,   4'b0000);
    check("rst_done",  a_done,  4'b0000);
    check("rst_err",   a_err,   4'b0000);
    check("rst_rx",    a_rx,    16'd0);
    check("rst_start", a_start, 1'b0);
    check("rst_txd",   a_txd,   16'd0);
    check("rst_cs_n",  a_cs_n,  4'b1111);
    tick();
    tick();
    RST_N = 1'b1;

    // Single request.
    EN = 1'b1; REQ = 4'b0001; TX_DATA = 64'h1111_2222_3333_A9A5;
    check("t1_pre_gnt", a_gnt, 4'b0000);
    tick();
    check("t1_gnt",   a_gnt,   4'b0001);
    check("t1_start", a_start, 1'b1);
    check("t1_txd",   a_txd,   16'hA9A5);
    REQ = 4'b0000; TX_DATA = 64'hFFFF_FFFF_FFFF_0000;
    M_CS_N = 1'b0; #1;
    check("t1_cs_lo", a_cs_n, 4'b1110);
    M_CS_N = 1'b1; #1;
    check("t1_cs_hi", a_cs_n, 4'b1111);
    tick();
    check("t1_txd_hold", a_txd, 16'hA9A5);
    check("t1_gnt_hold", a_gnt, 4'b0001);
    repeat (37) tick();
    M_SPI_DONE = 1'b1; M_RXDATA = 16'hF0A5;
    check("t1_done_early", a_done, 4'b0000);
    tick();
    check("t1_done",     a_done,  4'b0001);
    check("t1_rx",       a_rx,    16'hF0A5);
    check("t1_gnt_off",  a_gnt,   4'b0000);
    check("t1_start_off", a_start, 1'b0);
    REQ = 4'b0001;
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("t1_gap_gnt", a_gnt, 4'b0000);
      if (i == 2) check("t1_done_once", a_done, 4'b0000);
    end
    tick();
    check("t1_regrant", a_gnt, 4'b0001);
    check("t1_regrant_txd", a_txd, 16'h0000);
    M_SPI_DONE = 1'b0; REQ = 4'b0000;

    // Fairness with all four requesting continuously.
    RST_N = 1'b0; REQ = 4'b1111; EN = 1'b1; M_CS_N = 1'b1;
    TX_DATA = 64'h4444_3333_2222_1111;
    tick(); tick();
    RST_N = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt_a();
      check("rr_gnt", a_gnt, rr_exp[k]);
      M_SPI_DONE = 1'b1;
      tick();
      check("rr_done", a_done, rr_exp[k]);
      M_SPI_DONE = 1'b0;
    end

    // Timeout on the short-timeout instance, after one good transfer.
    REQ = 4'b0100; EN = 1'b1; M_SPI_DONE = 1'b0;
    do_reset();
    wait_gnt_b();
    check("to_gnt1", b_gnt, 4'b0100);
    M_RXDATA = 16'h1234; M_SPI_DONE = 1'b1;
    tick();
    check("to_done1", b_done, 4'b0100);
    check("to_rx1",   b_rx,   16'h1234);
    M_SPI_DONE = 1'b0; M_RXDATA = 16'hBEEF;
    tick();
    wait_gnt_b();
    check("to_gnt2", b_gnt, 4'b0100);
    early = 1'b0;
    repeat (15) begin
      tick();
      if (b_err != 4'b0000 || b_done != 4'b0000) early = 1'b1;
    end
    check("to_early", early, 1'b0);
    tick();
    check("to_err",    b_err,  4'b0100);
    check("to_nodone", b_done, 4'b0000);
    check("to_rx",     b_rx,   16'h1234);
    check("to_gnt",    b_gnt,  4'b0000);
    tick();
    check("to_err_once", b_err, 4'b0000);

    // Completion on the timeout cycle.
    REQ = 4'b0100;
    do_reset();
    wait_gnt_b();
    check("sim_gnt", b_gnt, 4'b0100);
    repeat (15) tick();
    M_SPI_DONE = 1'b1; M_RXDATA = 16'h5A5A;
    tick();
    check("sim_done", b_done, 4'b0100);
    check("sim_err",  b_err,  4'b0000);
    check("sim_rx",   b_rx,   16'h5A5A);
    tick();
    check("sim_err_late", b_err, 4'b0000);
    M_SPI_DONE = 1'b0;

    // Asynchronous reset mid-transaction.
    REQ = 4'b0010; EN = 1'b1; M_CS_N = 1'b0;
    do_reset();
    wait_gnt_a();
    check("ar_gnt", a_gnt, 4'b0010);
    REQ = 4'b0011;
    repeat (3) tick();
    check("ar_cs_n", a_cs_n, 4'b1101);
    #2 RST_N = 1'b0;
    #1;
    check("ar_gnt0",   a_gnt,   4'b0000);
    check("ar_start0", a_start, 1'b0);
    check("ar_cs_n0",  a_cs_n,  4'b1111);
    check("ar_done0",  a_done,  4'b0000);
    check("ar_err0",   a_err,   4'b0000);
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    check("ar_next_gnt", a_gnt, 4'b0001);

    // EN gating.
    RST_N = 1'b0; EN = 1'b0; REQ = 4'b0011; M_CS_N = 1'b1;
    tick(); tick();
    RST_N = 1'b1;
    repeat (5) begin
      tick();
      check("en_nogrant", a_gnt, 4'b0000);
    end
    EN = 1'b1;
    tick();
    check("en_gnt",   a_gnt,   4'b0001);
    check("en_start", a_start, 1'b1);
    EN = 1'b0; REQ = 4'b0000;
    repeat (3) tick();
    check("en_hold_gnt",   a_gnt,   4'b0001);
    check("en_hold_start", a_start, 1'b1);
    M_SPI_DONE = 1'b1; M_RXDATA = 16'h7E7E;
    tick();
    check("en_done", a_done, 4'b0001);
    check("en_rx",   a_rx,   16'h7E7E);
    M_SPI_DONE = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
